// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time, buffers the
// returned instruction with its PC and hands it to the IR over valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] redirect_word;

    assign redirect_word = redirect_pc & 32'hFFFF_FFFC;

    // During DRAIN the pc still holds the abandoned request's address, so the
    // request stays stable until its response; the new target waits in 'target'.
    assign mem_address = {pc[31:2], 2'b00};
    assign mem_read    = (state == FETCH) || (state == DRAIN);
    assign instr_valid = (state == HOLD) && !redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            target   <= 32'h0;
            instr    <= 32'h0;
            instr_pc <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect)
                        pc <= redirect_word;
                    state <= FETCH;
                end
                FETCH: begin
                    if (mem_resp) begin
                        if (redirect) begin
                            pc <= redirect_word;
                        end else begin
                            instr    <= mem_rdata;
                            instr_pc <= pc;
                            pc       <= pc + 32'd4;
                            state    <= HOLD;
                        end
                    end else if (redirect) begin
                        target <= redirect_word;
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_resp) begin
                        pc    <= redirect ? redirect_word : target;
                        state <= FETCH;
                    end else if (redirect) begin
                        target <= redirect_word;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= redirect_word;
                        state <= FETCH;
                    end else if (instr_ready) begin
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table for the main flow and
// redirects, plus hand-written sequences for async reset and PC wrap.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int compared;
    int mismatched;

    fetch_unit #(.RESET_PC(32'h0000_0060)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_address(mem_address),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_pc   (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        resp;
        logic [31:0] rdata;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] md(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic rdy,
                                input logic resp, input logic [31:0] rdata,
                                input logic e_read, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_instr,
                                input logic [31:0] e_pc);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.resp = resp; v.rdata = rdata;
        v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        redirect    = v.rd;
        redirect_pc = v.rpc;
        instr_ready = v.rdy;
        mem_resp    = v.resp;
        mem_rdata   = v.rdata;
    endtask

    // Wait for a request, answer it two cycles later, then check the delivered word.
    // Leaves instr_ready low so the caller decides what happens in HOLD.
    task automatic fetch_one(input logic [31:0] addr, input string tag);
        int n;
        n = 0;
        instr_ready = 1'b0;
        #1;
        while (!mem_read && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_output({tag, " req"}, {31'h0, mem_read}, 32'h1);
        check_output({tag, " addr"}, mem_address, addr);
        @(negedge clk);
        @(negedge clk);
        mem_resp  = 1'b1;
        mem_rdata = md(addr);
        #1;
        check_output({tag, " addr held"}, mem_address, addr);
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
        #1;
        check_output({tag, " valid"}, {31'h0, instr_valid}, 32'h1);
        check_output({tag, " instr"}, instr, md(addr));
        check_output({tag, " instr_pc"}, instr_pc, addr);
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        reset       = 1'b0;
        mem_rdata   = 32'h0;
        mem_resp    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b1;

        // Basic flow, HOLD back-pressure, redirect while pending / with resp / in HOLD, DRAIN
        vecs.push_back(mk(0, 0, 1, 0, 0,          0, 32'h060, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,          1, 32'h060, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,          1, 32'h060, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, md(32'h60), 1, 32'h060, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,          0, 32'h064, 1, 32'hA5A5_A5C5, 32'h60));
        vecs.push_back(mk(0, 0, 1, 0, 0,          1, 32'h064, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,          1, 32'h064, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, md(32'h64), 1, 32'h064, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,          0, 32'h068, 1, 32'hA5A5_A5C1, 32'h64));
        vecs.push_back(mk(0, 0, 1, 0, 0,          1, 32'h068, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,          1, 32'h068, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, md(32'h68), 1, 32'h068, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 32'h06C, 1, 32'hA5A5_A5CD, 32'h68));
        vecs.push_back(mk(0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h06C, 1, 32'hA5A5_A5CD, 32'h68));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 32'h06C, 1, 32'hA5A5_A5CD, 32'h68));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 32'h06C, 1, 32'hA5A5_A5CD, 32'h68));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 32'h06C, 1, 32'hA5A5_A5CD, 32'h68));
        vecs.push_back(mk(0, 0, 1, 0, 0,            0, 32'h06C, 1, 32'hA5A5_A5CD, 32'h68));
        vecs.push_back(mk(0, 0,       1, 0, 0,          1, 32'h06C, 0, 0, 0));
        vecs.push_back(mk(1, 32'h200, 1, 0, 0,          1, 32'h06C, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 0, 0,          1, 32'h06C, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 1, md(32'h6C), 1, 32'h06C, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 0, 0,           1, 32'h200, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 0, 0,           1, 32'h200, 0, 0, 0));
        vecs.push_back(mk(1, 32'h300, 1, 1, md(32'h200), 1, 32'h200, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 0, 0,           1, 32'h300, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 0, 0,           1, 32'h300, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 1, md(32'h300), 1, 32'h300, 0, 0, 0));
        vecs.push_back(mk(1, 32'h400, 1, 0, 0,           0, 32'h304, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 0, 0,           1, 32'h400, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 0, 0,           1, 32'h400, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 1, md(32'h400), 1, 32'h400, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 0, 0,           0, 32'h404, 1, 32'hA5A5_A1A5, 32'h400));
        vecs.push_back(mk(0, 0,       1, 0, 0,           1, 32'h404, 0, 0, 0));
        vecs.push_back(mk(1, 32'h500, 1, 0, 0,           1, 32'h404, 0, 0, 0));
        vecs.push_back(mk(1, 32'h504, 1, 0, 0,           1, 32'h404, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 1, md(32'h404), 1, 32'h404, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 0, 0,           1, 32'h504, 0, 0, 0));
        vecs.push_back(mk(1, 32'h503, 1, 0, 0,           1, 32'h504, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 1, md(32'h504), 1, 32'h504, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 0, 0,           1, 32'h500, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 1, md(32'h500), 1, 32'h500, 0, 0, 0));
        vecs.push_back(mk(0, 0,       1, 0, 0,           0, 32'h504, 1, 32'hA5A5_A0A5, 32'h500));
        vecs.push_back(mk(0, 0,       1, 0, 0,           1, 32'h504, 0, 0, 0));

        repeat (3) @(negedge clk);
        check_output("reset mem_read", {31'h0, mem_read}, 32'h0);
        check_output("reset valid", {31'h0, instr_valid}, 32'h0);
        check_output("reset addr", mem_address, 32'h60);
        check_output("reset instr", instr, 32'h0);
        check_output("reset instr_pc", instr_pc, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            #1;
            check_output($sformatf("v%0d mem_read", i), {31'h0, mem_read}, {31'h0, vecs[i].e_read});
            check_output($sformatf("v%0d addr", i), mem_address, vecs[i].e_addr);
            check_output($sformatf("v%0d valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                check_output($sformatf("v%0d instr", i), instr, vecs[i].e_instr);
                check_output($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].e_pc);
            end
            @(negedge clk);
        end

        // Asynchronous reset in the middle of an outstanding request
        #2;
        reset = 1'b0;
        #1;
        check_output("async rst mem_read", {31'h0, mem_read}, 32'h0);
        check_output("async rst valid", {31'h0, instr_valid}, 32'h0);
        check_output("async rst addr", mem_address, 32'h60);
        check_output("async rst instr", instr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b1;
        mem_resp  = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        check_output("late resp idle", {31'h0, mem_read}, 32'h0);
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
        fetch_one(32'h60, "restart");

        // Redirect from HOLD to the last word of the address space, then wrap
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        check_output("wrap redirect valid", {31'h0, instr_valid}, 32'h0);
        @(negedge clk);
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        fetch_one(32'hFFFF_FFFC, "top");
        @(negedge clk);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        fetch_one(32'h0, "wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
